// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through fetch/decode/execute
// states, drives datapath enables and selects, and counts retired instructions.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JAL    = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_RTY  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_ADDU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [3:0]       w_imm_alu_op;
    logic [CNT_W-1:0] r_retired;
    logic             w_unused_funct;

    // funct reaches the ALU control directly; the sequencer never decodes it
    assign w_unused_funct = ^funct;

    always_comb begin
        w_imm_alu_op = ALU_ADD;
        case (op)
            OP_ADDIU: w_imm_alu_op = ALU_ADDU;
            OP_SLTI:  w_imm_alu_op = ALU_SLT;
            OP_SLTIU: w_imm_alu_op = ALU_SLTU;
            OP_ANDI:  w_imm_alu_op = ALU_AND;
            OP_ORI:   w_imm_alu_op = ALU_OR;
            OP_XORI:  w_imm_alu_op = ALU_XOR;
            default:  w_imm_alu_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_source  = 2'b00;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    pc_en    = 1'b1;
                    ir_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW:    w_next = S_MEMADR;
                    OP_RTYPE:        w_next = S_EXEC;
                    OP_BEQ, OP_BNE:  w_next = S_BRANCH;
                    OP_J:            w_next = S_JUMP;
                    OP_JAL:          w_next = S_JAL;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI: w_next = S_IEXEC;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTY;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_en     = (op == OP_BNE) ? ~zero : zero;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            // link uses the pre-update PC since the register write and PC load share this edge
            S_JAL: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = w_imm_alu_op;
                w_next    = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                alu_op    = w_imm_alu_op;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        if (rst) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            mem_read   = 1'b0;
            illegal_op = 1'b0;
            w_retire   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; a narrow-counter second instance checks wrap.
module tb_multicycle_control_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic        alu_src_a, illegal_op;
    logic [3:0]  alu_op, state;
    logic [31:0] retired;

    logic        n_unused_pc_en, n_unused_iord, n_unused_mem_read, n_unused_mem_write;
    logic        n_unused_ir_write, n_unused_reg_write, n_unused_alu_src_a, n_unused_illegal_op;
    logic [1:0]  n_unused_reg_dst, n_unused_mem_to_reg, n_unused_alu_src_b, n_unused_pc_source;
    logic [3:0]  n_unused_alu_op, n_state;
    logic [1:0]  n_retired;

    int n_checks;
    int n_fails;

    multicycle_control_fsm #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal_op(illegal_op), .state(state), .retired(retired)
    );

    multicycle_control_fsm #(.CNT_W(2)) u_dut_narrow (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(n_unused_pc_en), .iord(n_unused_iord), .mem_read(n_unused_mem_read),
        .mem_write(n_unused_mem_write), .ir_write(n_unused_ir_write),
        .reg_write(n_unused_reg_write), .reg_dst(n_unused_reg_dst),
        .mem_to_reg(n_unused_mem_to_reg), .alu_src_a(n_unused_alu_src_a),
        .alu_src_b(n_unused_alu_src_b), .alu_op(n_unused_alu_op),
        .pc_source(n_unused_pc_source), .illegal_op(n_unused_illegal_op),
        .state(n_state), .retired(n_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs settle well away from the edge
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        op        = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // reset: FETCH would normally assert mem_read/pc_en/ir_write with mem_ready=1
        tick();
        tick();
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("rst_pc_en", 32'(pc_en), 32'd0);
        check_eq("rst_ir_write", 32'(ir_write), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("fetch_pc_en", 32'(pc_en), 32'd1);
        check_eq("fetch_ir_write", 32'(ir_write), 32'd1);
        check_eq("fetch_alu_src_b", 32'(alu_src_b), 32'd1);

        // R-type: 0,1,6,7,0
        tick(); #1;
        check_eq("r_decode", 32'(state), 32'd1);
        check_eq("r_decode_srcb", 32'(alu_src_b), 32'd3);
        tick(); #1;
        check_eq("r_exec", 32'(state), 32'd6);
        check_eq("r_exec_aluop", 32'(alu_op), 32'd2);
        check_eq("r_exec_srca", 32'(alu_src_a), 32'd1);
        tick(); #1;
        check_eq("r_aluwb", 32'(state), 32'd7);
        check_eq("r_aluwb_regw", 32'(reg_write), 32'd1);
        check_eq("r_aluwb_dst", 32'(reg_dst), 32'd1);
        check_eq("r_aluwb_ret0", retired, 32'd0);
        tick(); #1;
        check_eq("r_back_fetch", 32'(state), 32'd0);
        check_eq("r_retired1", retired, 32'd1);

        // lw with two MEMRD wait cycles: 0,1,2,3,3,3,4,0
        op = 6'b100011;
        tick(); #1;
        check_eq("lw_decode", 32'(state), 32'd1);
        tick(); #1;
        check_eq("lw_memadr", 32'(state), 32'd2);
        check_eq("lw_memadr_srcb", 32'(alu_src_b), 32'd2);
        tick();
        mem_ready = 1'b0;
        #1;
        check_eq("lw_memrd0", 32'(state), 32'd3);
        check_eq("lw_memrd0_iord", 32'(iord), 32'd1);
        check_eq("lw_memrd0_rd", 32'(mem_read), 32'd1);
        tick(); #1;
        check_eq("lw_memrd1", 32'(state), 32'd3);
        check_eq("lw_memrd1_iord", 32'(iord), 32'd1);
        tick();
        mem_ready = 1'b1;
        #1;
        check_eq("lw_memrd2", 32'(state), 32'd3);
        tick(); #1;
        check_eq("lw_memwb", 32'(state), 32'd4);
        check_eq("lw_memwb_regw", 32'(reg_write), 32'd1);
        check_eq("lw_memwb_m2r", 32'(mem_to_reg), 32'd1);
        tick(); #1;
        check_eq("lw_fetch", 32'(state), 32'd0);
        check_eq("lw_retired2", retired, 32'd2);

        // sw with one FETCH wait and one MEMWR wait
        op = 6'b101011;
        mem_ready = 1'b0;
        #1;
        check_eq("sw_fetch_wait_pc_en", 32'(pc_en), 32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        check_eq("sw_fetch_held", 32'(state), 32'd0);
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        check_eq("sw_memwr0", 32'(state), 32'd5);
        check_eq("sw_memwr0_wr", 32'(mem_write), 32'd1);
        tick();
        mem_ready = 1'b1;
        #1;
        check_eq("sw_memwr1", 32'(state), 32'd5);
        check_eq("sw_memwr1_wr", 32'(mem_write), 32'd1);
        check_eq("sw_ret_pending", retired, 32'd2);
        tick(); #1;
        check_eq("sw_retired3", retired, 32'd3);
        check_eq("narrow_at_max", 32'(n_retired), 32'd3);

        // beq taken
        op = 6'b000100;
        zero = 1'b1;
        tick(); tick(); #1;
        check_eq("beq_state", 32'(state), 32'd8);
        check_eq("beq_pc_en", 32'(pc_en), 32'd1);
        check_eq("beq_pcsrc", 32'(pc_source), 32'd1);
        check_eq("beq_aluop", 32'(alu_op), 32'd1);
        zero = 1'b0;
        #1;
        check_eq("beq_nottaken", 32'(pc_en), 32'd0);
        zero = 1'b1;
        tick(); #1;
        check_eq("beq_retired4", retired, 32'd4);
        check_eq("narrow_wrap", 32'(n_retired), 32'd0);

        // bne with zero=1 is not taken
        op = 6'b000101;
        tick(); tick(); #1;
        check_eq("bne_state", 32'(state), 32'd8);
        check_eq("bne_pc_en", 32'(pc_en), 32'd0);
        tick(); #1;
        check_eq("bne_retired5", retired, 32'd5);

        // jal
        op = 6'b000011;
        tick(); tick(); #1;
        check_eq("jal_state", 32'(state), 32'd10);
        check_eq("jal_pc_en", 32'(pc_en), 32'd1);
        check_eq("jal_reg_dst", 32'(reg_dst), 32'd2);
        check_eq("jal_m2r", 32'(mem_to_reg), 32'd2);
        check_eq("jal_regw", 32'(reg_write), 32'd1);
        check_eq("jal_pcsrc", 32'(pc_source), 32'd2);
        tick(); #1;
        check_eq("jal_retired6", retired, 32'd6);

        // ori
        op = 6'b001101;
        tick(); tick(); #1;
        check_eq("ori_iexec", 32'(state), 32'd11);
        check_eq("ori_iexec_aluop", 32'(alu_op), 32'd3);
        check_eq("ori_iexec_srcb", 32'(alu_src_b), 32'd2);
        tick(); #1;
        check_eq("ori_iwb", 32'(state), 32'd12);
        check_eq("ori_iwb_regw", 32'(reg_write), 32'd1);
        check_eq("ori_iwb_dst", 32'(reg_dst), 32'd0);
        check_eq("ori_iwb_aluop", 32'(alu_op), 32'd3);
        tick(); #1;
        check_eq("ori_retired7", retired, 32'd7);

        // illegal opcode
        op = 6'b111111;
        check_eq("ill_fetch_flag", 32'(illegal_op), 32'd0);
        tick(); #1;
        check_eq("ill_decode", 32'(state), 32'd1);
        check_eq("ill_flag", 32'(illegal_op), 32'd1);
        tick(); #1;
        check_eq("ill_back_fetch", 32'(state), 32'd0);
        check_eq("ill_flag_clear", 32'(illegal_op), 32'd0);
        check_eq("ill_retired7", retired, 32'd7);

        // reset in the middle of a MEMRD wait
        op = 6'b100011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        check_eq("rr_in_memrd", 32'(state), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("rr_state", 32'(state), 32'd0);
        check_eq("rr_retired", retired, 32'd0);
        check_eq("rr_mem_read", 32'(mem_read), 32'd0);
        check_eq("rr_narrow", 32'(n_retired), 32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        check_eq("rr_held_pc_en", 32'(pc_en), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rr_fetch_pc_en", 32'(pc_en), 32'd1);
        check_eq("rr_fetch_ir_write", 32'(ir_write), 32'd1);
        tick(); #1;
        check_eq("rr_decode", 32'(state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
